// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: command codes and helpers shared by the SPI command encoder and decoder.
package spi_cmd_pkg;
   typedef enum logic [2:0] {
      CMD_GETROLLANGULAR  = 3'b000,
      CMD_GETPITCHANGULAR = 3'b001,
      CMD_GETYAWANGULAR   = 3'b010,
      CMD_GETPITCHLINEAR  = 3'b011,
      CMD_GETROLLLINEAR   = 3'b100,
      CMD_GETYAWLINEAR    = 3'b101
   } cmd_e;
   localparam int BYTE_COUNT = 3;
   function automatic logic is_angular(input logic [2:0] c);
      return c <= CMD_GETYAWANGULAR;
   endfunction
   function automatic logic is_reserved(input logic [2:0] c);
      return c > CMD_GETYAWLINEAR;
   endfunction
endpackage

// File: rtl/spi_decoder.sv
// spi_decoder: drops the dummy byte, assembles a 16-bit little-endian reading, presents it on valid/ack.
// Optional inter-byte timeout compiled in with SPI_DECODER_TIMEOUT_EN.
module spi_decoder
   import spi_cmd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  command,
   input  logic        rx_dv,
   input  logic [7:0]  rx_byte,
   input  logic        data_ack,
   output logic [15:0] data,
   output logic [2:0]  data_cmd,
   output logic        data_angular,
   output logic        data_valid,
   output logic [1:0]  rx_count,
   output logic        busy,
   output logic        error
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_DUMMY = 3'd1;
   localparam logic [2:0] S_LO    = 3'd2;
   localparam logic [2:0] S_HI    = 3'd3;
   localparam logic [2:0] S_HOLD  = 3'd4;
   logic [2:0]  state_q, state_d;
   logic [2:0]  cmd_q, cmd_d;
   logic [7:0]  lo_q, lo_d;
   logic [15:0] data_q, data_d;
   logic [2:0]  data_cmd_q, data_cmd_d;
   logic        ang_q, ang_d;
   logic        valid_q, valid_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        err_q, err_d;
   logic        timeout;
`ifdef SPI_DECODER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q, tmo_d;
   logic          waiting;
   // The counter restarts on every byte, so the limit applies per gap, not per transfer.
   assign waiting = state_q == S_DUMMY || state_q == S_LO || state_q == S_HI;
   assign timeout = waiting && !rx_dv && tmo_q == TW'(TIMEOUT_CYCLES - 1);
   assign tmo_d   = (!waiting || rx_dv || timeout) ? '0 : tmo_q + 1'b1;
   always_ff @(posedge clk)
      if (rst) tmo_q <= '0;
      else tmo_q <= tmo_d;
`else
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT_CYCLES;
   assign timeout = 1'b0;
`endif
   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      lo_d       = lo_q;
      data_d     = data_q;
      data_cmd_d = data_cmd_q;
      ang_d      = ang_q;
      valid_d    = valid_q;
      cnt_d      = cnt_q;
      err_d      = 1'b0;
      case (state_q)
         S_IDLE:
            if (start && is_reserved(command)) err_d = 1'b1;
            else if (start) begin
               cmd_d   = command;
               cnt_d   = 2'd0;
               state_d = S_DUMMY;
            end
         S_DUMMY:
            if (rx_dv) begin
               cnt_d   = 2'd1;
               state_d = S_LO;
            end
         S_LO:
            if (rx_dv) begin
               lo_d    = rx_byte;
               cnt_d   = 2'd2;
               state_d = S_HI;
            end
         S_HI:
            if (rx_dv) begin
               data_d     = {rx_byte, lo_q};
               data_cmd_d = cmd_q;
               ang_d      = is_angular(cmd_q);
               valid_d    = 1'b1;
               cnt_d      = 2'(BYTE_COUNT);
               state_d    = S_HOLD;
            end
         S_HOLD:
            if (data_ack) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
         default: state_d = S_IDLE;
      endcase
      if (timeout) begin
         state_d = S_IDLE;
         cnt_d   = 2'd0;
         err_d   = 1'b1;
      end
   end
   always_ff @(posedge clk)
      if (rst) begin
         state_q    <= S_IDLE;
         cmd_q      <= '0;
         lo_q       <= '0;
         data_q     <= '0;
         data_cmd_q <= '0;
         ang_q      <= 1'b0;
         valid_q    <= 1'b0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         lo_q       <= lo_d;
         data_q     <= data_d;
         data_cmd_q <= data_cmd_d;
         ang_q      <= ang_d;
         valid_q    <= valid_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   assign data         = data_q;
   assign data_cmd     = data_cmd_q;
   assign data_angular = ang_q;
   assign data_valid   = valid_q;
   assign rx_count     = cnt_q;
   assign busy         = state_q != S_IDLE;
   assign error        = err_q;
endmodule
